// File: rtl/cmsdk_apb_to_ahb.sv
// APB4 completer to AHB-Lite manager bridge: one APB access becomes one single AHB transfer.
// Optional macro CMSDK_APB_TO_AHB_STRB_CHECK_EN rejects illegal write strobes with PSLVERR.
module cmsdk_apb_to_ahb #(
  parameter int ADDRWIDTH = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic [31:0]          PWDATA,
  input  logic [3:0]           PSTRB,
  input  logic [2:0]           PPROT,
  output logic                 PREADY,
  output logic [31:0]          PRDATA,
  output logic                 PSLVERR,
  output logic [ADDRWIDTH-1:0] HADDR,
  output logic [1:0]           HTRANS,
  output logic [2:0]           HSIZE,
  output logic                 HWRITE,
  output logic [3:0]           HPROT,
  output logic [2:0]           HBURST,
  output logic                 HMASTLOCK,
  output logic [31:0]          HWDATA,
  input  logic                 HREADY,
  input  logic [31:0]          HRDATA,
  input  logic                 HRESP,
  output logic                 BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } state_t;

`ifdef CMSDK_APB_TO_AHB_STRB_CHECK_EN
  localparam logic STRB_CHECK = 1'b1;
`else
  localparam logic STRB_CHECK = 1'b0;
`endif

  // Returns {legal, hsize[2:0], haddr[1:0]} for a write strobe pattern.
  function automatic logic [5:0] strb_decode(input logic [3:0] strb);
    logic [5:0] res;
    case (strb)
      4'b1111: res = {1'b1, 3'b010, 2'b00};
      4'b0011: res = {1'b1, 3'b001, 2'b00};
      4'b1100: res = {1'b1, 3'b001, 2'b10};
      4'b0001: res = {1'b1, 3'b000, 2'b00};
      4'b0010: res = {1'b1, 3'b000, 2'b01};
      4'b0100: res = {1'b1, 3'b000, 2'b10};
      4'b1000: res = {1'b1, 3'b000, 2'b11};
      default: res = {1'b0, 3'b010, 2'b00};
    endcase
    return res;
  endfunction

  state_t                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   haddr_q;
  logic [2:0]             hsize_q;
  logic                   hwrite_q;
  logic [3:0]             hprot_q;
  logic [31:0]            hwdata_q;
  logic [31:0]            prdata_q;
  logic                   pslverr_q;
  logic                   abort_q;

  logic [5:0]             strb_dec_s;
  logic                   setup_s;
  logic                   reject_s;
  logic                   discard_s;
  logic [1:0]             htrans_s;
  logic                   pready_s;
  logic                   busy_s;
  logic                   unused_s;

  assign strb_dec_s = strb_decode(PSTRB);
  assign setup_s    = PSEL & ~PENABLE;
  assign reject_s   = STRB_CHECK & PWRITE & ~strb_dec_s[5];
  assign discard_s  = abort_q | ~PSEL;
  assign unused_s   = ^{PADDR[1:0], PPROT[1]};

  // State register
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (setup_s) begin
          if (reject_s) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_ADDR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (HREADY) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded purely from the state register
  always_comb begin
    htrans_s = 2'b00;
    pready_s = 1'b0;
    busy_s   = 1'b1;
    case (state_q)
      ST_IDLE: busy_s   = 1'b0;
      ST_ADDR: htrans_s = 2'b10;
      ST_DATA: htrans_s = 2'b00;
      ST_RESP: pready_s = 1'b1;
      default: busy_s   = 1'b0;
    endcase
  end

  // Transfer attributes and APB response registers
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      haddr_q   <= '0;
      hsize_q   <= 3'b000;
      hwrite_q  <= 1'b0;
      hprot_q   <= 4'b0000;
      hwdata_q  <= 32'h0000_0000;
      prdata_q  <= 32'h0000_0000;
      pslverr_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (setup_s) begin
            haddr_q   <= {PADDR[ADDRWIDTH-1:2], PWRITE ? strb_dec_s[1:0] : 2'b00};
            hsize_q   <= PWRITE ? strb_dec_s[4:2] : 3'b010;
            hwrite_q  <= PWRITE;
            hprot_q   <= {2'b00, PPROT[0], ~PPROT[2]};
            hwdata_q  <= PWDATA;
            abort_q   <= 1'b0;
            prdata_q  <= 32'h0000_0000;
            pslverr_q <= reject_s;
          end
        end
        ST_ADDR: begin
          if (!PSEL) begin
            abort_q <= 1'b1;
          end
        end
        ST_DATA: begin
          // A response for an access the APB master abandoned is dropped
          if (HREADY) begin
            pslverr_q <= HRESP & ~discard_s;
            prdata_q  <= (hwrite_q | discard_s | HRESP) ? 32'h0000_0000 : HRDATA;
          end else if (!PSEL) begin
            abort_q <= 1'b1;
          end
        end
        ST_RESP: begin
          prdata_q  <= 32'h0000_0000;
          pslverr_q <= 1'b0;
        end
        default: begin
          prdata_q  <= 32'h0000_0000;
          pslverr_q <= 1'b0;
        end
      endcase
    end
  end

  assign PREADY    = pready_s;
  assign PRDATA    = prdata_q;
  assign PSLVERR   = pslverr_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_s;
  assign HSIZE     = hsize_q;
  assign HWRITE    = hwrite_q;
  assign HPROT     = hprot_q;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = hwdata_q;
  assign BUSY      = busy_s;

endmodule

// File: tb/tb_cmsdk_apb_to_ahb.sv
// Directed and randomized bench for cmsdk_apb_to_ahb with a cycle-level AHB slave
// and an APB-access reference model derived from strobe arithmetic.
module tb_cmsdk_apb_to_ahb;

`ifdef CMSDK_APB_TO_AHB_STRB_CHECK_EN
  localparam bit STRB_CHK = 1'b1;
`else
  localparam bit STRB_CHK = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic [15:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [3:0]  HPROT;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        BUSY;

  int checks   = 0;
  int failures = 0;

  cmsdk_apb_to_ahb #(.ADDRWIDTH(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HPROT(HPROT), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .BUSY(BUSY)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".PREADY"}, {31'd0, PREADY}, 32'd0);
    chk({tag, ".PRDATA"}, PRDATA, 32'd0);
    chk({tag, ".PSLVERR"}, {31'd0, PSLVERR}, 32'd0);
    chk({tag, ".HADDR"}, {16'd0, HADDR}, 32'd0);
    chk({tag, ".HTRANS"}, {30'd0, HTRANS}, 32'd0);
    chk({tag, ".HSIZE"}, {29'd0, HSIZE}, 32'd0);
    chk({tag, ".HWRITE"}, {31'd0, HWRITE}, 32'd0);
    chk({tag, ".HPROT"}, {28'd0, HPROT}, 32'd0);
    chk({tag, ".HWDATA"}, HWDATA, 32'd0);
    chk({tag, ".BUSY"}, {31'd0, BUSY}, 32'd0);
    chk({tag, ".HBURST"}, {29'd0, HBURST}, 32'd0);
    chk({tag, ".HMASTLOCK"}, {31'd0, HMASTLOCK}, 32'd0);
  endtask

  // Idle APB bus for n cycles; the bridge must sit in IDLE with a cleared response.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge HCLK);
      PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
      chk("idle.PREADY", {31'd0, PREADY}, 32'd0);
      chk("idle.PRDATA", PRDATA, 32'd0);
      chk("idle.PSLVERR", {31'd0, PSLVERR}, 32'd0);
      chk("idle.BUSY", {31'd0, BUSY}, 32'd0);
      chk("idle.HTRANS", {30'd0, HTRANS}, 32'd0);
    end
  endtask

  // One APB access. aw/dw are HREADY-low cycles in the AHB address/data phase,
  // err requests a two-cycle ERROR response, drop deasserts PSEL after setup.
  task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb, input logic [2:0] prot, input int aw,
                      input int dw, input logic err, input logic [31:0] rd, input logic drop);
    int          cnt, low, last;
    logic        legal, reject;
    logic [1:0]  lowb;
    logic [15:0] e_haddr;
    logic [2:0]  e_hsize;
    logic [3:0]  e_hprot;
    logic [31:0] e_prdata;
    logic        e_err;
    cnt = $countones(strb);
    low = 0;
    for (int i = 3; i >= 0; i--) if (strb[i]) low = i;
    lowb  = low[1:0];
    legal = (cnt == 1) || (cnt == 4) || (cnt == 2 && (low % 2 == 0) && strb[low+1]);
    reject = STRB_CHK && wr && !legal;
    e_haddr = {addr[15:2], (wr && legal) ? lowb : 2'b00};
    e_hsize = (wr && legal) ? 3'($clog2(cnt)) : 3'd2;
    e_hprot = {2'b00, prot[0], ~prot[2]};
    e_err    = err && !drop;
    e_prdata = (wr || err || drop) ? 32'd0 : rd;

    @(negedge HCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    PSTRB = strb; PPROT = prot; HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;

    if (reject) begin
      @(negedge HCLK);
      PENABLE = 1'b1;
      chk("rej.PREADY", {31'd0, PREADY}, 32'd1);
      chk("rej.PSLVERR", {31'd0, PSLVERR}, 32'd1);
      chk("rej.PRDATA", PRDATA, 32'd0);
      chk("rej.HTRANS", {30'd0, HTRANS}, 32'd0);
      chk("rej.BUSY", {31'd0, BUSY}, 32'd1);
    end else begin
      last = 3 + aw + dw;
      for (int c = 1; c <= last; c++) begin
        @(negedge HCLK);
        if (drop) begin
          PSEL = 1'b0; PENABLE = 1'b0;
        end else begin
          PENABLE = 1'b1;
        end
        chk("xf.BUSY", {31'd0, BUSY}, 32'd1);
        chk("xf.PREADY", {31'd0, PREADY}, {31'd0, c == last});
        if (c <= 1 + aw) begin
          chk("addr.HTRANS", {30'd0, HTRANS}, 32'h2);
          chk("addr.HADDR", {16'd0, HADDR}, {16'd0, e_haddr});
          chk("addr.HSIZE", {29'd0, HSIZE}, {29'd0, e_hsize});
          chk("addr.HWRITE", {31'd0, HWRITE}, {31'd0, wr});
          chk("addr.HPROT", {28'd0, HPROT}, {28'd0, e_hprot});
          HREADY = (c == 1 + aw); HRESP = 1'b0; HRDATA = $urandom;
        end else if (c < last) begin
          chk("data.HTRANS", {30'd0, HTRANS}, 32'd0);
          if (wr) chk("data.HWDATA", HWDATA, wd);
          HREADY = (c == last - 1);
          HRESP  = err && (c >= last - 2);
          HRDATA = (c == last - 1) ? (err ? 32'd0 : rd) : $urandom;
        end else begin
          chk("resp.HTRANS", {30'd0, HTRANS}, 32'd0);
          chk("resp.PRDATA", PRDATA, e_prdata);
          chk("resp.PSLVERR", {31'd0, PSLVERR}, {31'd0, e_err});
          HREADY = 1'b1; HRESP = 1'b0;
        end
      end
    end
  endtask

  initial begin
    HRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 16'h0;
    PWDATA = 32'h0; PSTRB = 4'h0; PPROT = 3'h0; HREADY = 1'b1; HRDATA = 32'h0; HRESP = 1'b0;
    repeat (3) @(negedge HCLK);
    chk_all_zero("reset");
    HRESETn = 1'b1;
    idle(1);

    // Directed cases
    xfer(1'b0, 16'h1234, 32'h0, 4'h0, 3'b000, 0, 0, 1'b0, 32'hCAFEF00D, 1'b0);
    idle(1);
    xfer(1'b1, 16'h0040, 32'h00AB0000, 4'b0100, 3'b101, 0, 0, 1'b0, 32'h0, 1'b0);
    xfer(1'b1, 16'h0F08, 32'h12345678, 4'b1111, 3'b001, 0, 3, 1'b0, 32'h0, 1'b0);
    idle(1);
    xfer(1'b0, 16'h2000, 32'h0, 4'hF, 3'b100, 1, 1, 1'b1, 32'hDEADBEEF, 1'b0);
    xfer(1'b0, 16'h2004, 32'h0, 4'hF, 3'b000, 0, 0, 1'b0, 32'h0BADF00D, 1'b0);
    idle(1);
    xfer(1'b1, 16'h2346, 32'h11112222, 4'b0101, 3'b000, 0, 0, 1'b0, 32'h0, 1'b0);
    idle(1);
    xfer(1'b1, 16'h3002, 32'h55AA55AA, 4'b1100, 3'b000, 2, 0, 1'b0, 32'h0, 1'b0);
    xfer(1'b0, 16'h3100, 32'h0, 4'h0, 3'b000, 1, 2, 1'b1, 32'h77777777, 1'b1);
    idle(1);
    xfer(1'b1, 16'h3104, 32'h0, 4'b0000, 3'b010, 0, 0, 1'b0, 32'h0, 1'b0);
    idle(1);

    // Synchronous reset during the AHB data phase abandons the transfer
    @(negedge HCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 16'h0ABC; HREADY = 1'b1;
    @(negedge HCLK);
    PENABLE = 1'b1; HREADY = 1'b1;
    @(negedge HCLK);
    chk("rstd.HTRANS", {30'd0, HTRANS}, 32'd0);
    HRESETn = 1'b0; HREADY = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge HCLK);
    chk_all_zero("rst_data");
    HRESETn = 1'b1; HREADY = 1'b1;
    xfer(1'b0, 16'h0ABC, 32'h0, 4'h0, 3'b000, 0, 0, 1'b0, 32'h13579BDF, 1'b0);
    idle(1);

    // Randomized accesses
    for (int n = 0; n < 60; n++) begin
      logic        r_wr, r_err, r_drop;
      int          r_dw;
      r_wr   = 1'($urandom_range(0, 1));
      r_err  = ($urandom_range(0, 3) == 0);
      r_drop = ($urandom_range(0, 7) == 0);
      r_dw   = $urandom_range(0, 3);
      if (r_err && r_dw == 0) r_dw = 1;
      xfer(r_wr, 16'($urandom), $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
           $urandom_range(0, 2), r_dw, r_err, $urandom, r_drop);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
